// File: rtl/ariane_pkg.sv
// Shared types for the commit-port fence sequencer: fence kinds and FSM states.
package ariane_pkg;

  typedef enum logic [1:0] {
    FK_FENCE   = 2'd0,
    FK_FENCE_I = 2'd1,
    FK_SFENCE  = 2'd2,
    FK_DFLUSH  = 2'd3
  } fence_kind_t;

  typedef enum logic [2:0] {
    IDLE,
    DRAIN,
    FLUSH_D,
    FLUSH_I,
    FLUSH_TLB,
    DONE
  } fence_seq_state_e;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that holds once it reaches MAX.
module sat_counter #(
  parameter int MAX = 1024,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc && (count != MAX_V)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/commit_fence_sequencer.sv
// Retires fence-class instructions at commit port 0: store drain, cache/TLB flush
// handshakes, then a one-cycle commit acknowledge. All outputs decode registered state.
module commit_fence_sequencer
  import ariane_pkg::*;
#(
  parameter int DRAIN_TIMEOUT = 1024,
  parameter int CNT_W         = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_valid_i,
  input  logic [1:0]       req_kind_i,
  input  logic             halt_i,
  input  logic             kill_i,
  input  logic             no_st_pending_i,
  output logic             dcache_flush_o,
  input  logic             dcache_flush_ack_i,
  output logic             icache_flush_o,
  output logic             tlb_flush_o,
  output logic             commit_ack_o,
  output logic             busy_o,
  output logic             drain_timeout_o,
  output logic [CNT_W-1:0] fence_cnt_o
);

  localparam int              DCNT_W = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [DCNT_W-1:0] DT_V = DCNT_W'(DRAIN_TIMEOUT);

  fence_seq_state_e  state_q, state_d;
  fence_kind_t       kind_q;
  logic [DCNT_W-1:0] drain_cnt;
  logic [CNT_W-1:0]  fence_cnt_q;
  logic              accept;
  logic              drain_inc;

  assign accept    = (state_q == IDLE) && req_valid_i && !halt_i && !kill_i;
  assign drain_inc = (state_q == DRAIN) && !kill_i && !no_st_pending_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      kind_q  <= FK_FENCE;
    end else begin
      state_q <= state_d;
      if (accept) kind_q <= fence_kind_t'(req_kind_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fence_cnt_q <= '0;
    end else if (state_q == DONE) begin
      fence_cnt_q <= fence_cnt_q + CNT_W'(1);
    end
  end

  sat_counter #(
    .MAX (DRAIN_TIMEOUT),
    .W   (DCNT_W)
  ) u_drain_cnt (
    .clk   (clk_i),
    .rst   (rst_i),
    .clr   (accept),
    .inc   (drain_inc),
    .count (drain_cnt)
  );

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d         = state_q;
    dcache_flush_o  = 1'b0;
    icache_flush_o  = 1'b0;
    tlb_flush_o     = 1'b0;
    commit_ack_o    = 1'b0;
    drain_timeout_o = 1'b0;
    busy_o          = (state_q != IDLE);
    unique case (state_q)
      IDLE: begin
        if (accept) state_d = DRAIN;
      end
      DRAIN: begin
        drain_timeout_o = (drain_cnt == DT_V);
        // Kill beats a simultaneous drain completion.
        if (kill_i) begin
          state_d = IDLE;
        end else if (no_st_pending_i) begin
          state_d = (kind_q == FK_SFENCE) ? FLUSH_TLB : FLUSH_D;
        end
      end
      FLUSH_D: begin
        dcache_flush_o = 1'b1;
        // The D$ handshake is never abandoned, so kill is not looked at here.
        if (dcache_flush_ack_i) state_d = (kind_q == FK_FENCE_I) ? FLUSH_I : DONE;
      end
      FLUSH_I: begin
        icache_flush_o = 1'b1;
        state_d        = DONE;
      end
      FLUSH_TLB: begin
        tlb_flush_o = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        commit_ack_o = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign fence_cnt_o = fence_cnt_q;

endmodule

// File: tb/tb_commit_fence_sequencer.sv
// Directed bench for commit_fence_sequencer: per-cycle output traces compared with hand-derived bit masks.
module tb_commit_fence_sequencer;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       req_valid_i;
  logic [1:0] req_kind_i;
  logic       halt_i;
  logic       kill_i;
  logic       no_st_pending_i;
  logic       dcache_flush_o;
  logic       dcache_flush_ack_i;
  logic       icache_flush_o;
  logic       tlb_flush_o;
  logic       commit_ack_o;
  logic       busy_o;
  logic       drain_timeout_o;
  logic [1:0] fence_cnt_o;

  int         total = 0;
  int         bad   = 0;
  logic [1:0] exp_cnt;
  logic [63:0] rec_dflush, rec_iflush, rec_tlb, rec_ack, rec_busy, rec_tmo;

  commit_fence_sequencer #(
    .DRAIN_TIMEOUT (4),
    .CNT_W         (2)
  ) dut (
    .clk_i              (clk_i),
    .rst_i              (rst_i),
    .req_valid_i        (req_valid_i),
    .req_kind_i         (req_kind_i),
    .halt_i             (halt_i),
    .kill_i             (kill_i),
    .no_st_pending_i    (no_st_pending_i),
    .dcache_flush_o     (dcache_flush_o),
    .dcache_flush_ack_i (dcache_flush_ack_i),
    .icache_flush_o     (icache_flush_o),
    .tlb_flush_o        (tlb_flush_o),
    .commit_ack_o       (commit_ack_o),
    .busy_o             (busy_o),
    .drain_timeout_o    (drain_timeout_o),
    .fence_cnt_o        (fence_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Step into the next cycle; inputs set and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid_i = 1'b0; req_kind_i = 2'd0; halt_i = 1'b0; kill_i = 1'b0;
    no_st_pending_i = 1'b1; dcache_flush_ack_i = 1'b0;
  endtask

  // Drives one request from cycle 0 (the accept cycle) for n cycles and records every output per cycle.
  // The request is held until ack or kill; its kind is flipped once busy_o is seen.
  task automatic run_seq(input logic [1:0] kind, input int n,
                         input logic [63:0] nst, input logic [63:0] dack,
                         input logic [63:0] kill, input logic [63:0] halt);
    logic drop;
    logic changed;
    drop = 1'b0; changed = 1'b0;
    rec_dflush = '0; rec_iflush = '0; rec_tlb = '0; rec_ack = '0; rec_busy = '0; rec_tmo = '0;
    req_valid_i = 1'b1; req_kind_i = kind;
    no_st_pending_i = nst[0]; dcache_flush_ack_i = dack[0]; kill_i = kill[0]; halt_i = halt[0];
    for (int c = 1; c <= n; c++) begin
      tick();
      rec_dflush[c] = dcache_flush_o; rec_iflush[c] = icache_flush_o; rec_tlb[c] = tlb_flush_o;
      rec_ack[c] = commit_ack_o; rec_busy[c] = busy_o; rec_tmo[c] = drain_timeout_o;
      if (kill[c-1] || commit_ack_o) drop = 1'b1;
      if (busy_o && !changed) begin
        req_kind_i = req_kind_i ^ 2'b01;
        changed = 1'b1;
      end
      req_valid_i = !drop;
      no_st_pending_i = nst[c]; dcache_flush_ack_i = dack[c]; kill_i = kill[c]; halt_i = halt[c];
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    req_valid_i = 1'b1;
    rst_i = 1'b1;
    tick();
    tick();
    total++; if ({dcache_flush_o, icache_flush_o, tlb_flush_o, commit_ack_o, busy_o, drain_timeout_o} !== 6'b0) begin bad++; $display("FAIL reset_outputs got=%b exp=000000", {dcache_flush_o, icache_flush_o, tlb_flush_o, commit_ack_o, busy_o, drain_timeout_o}); end
    total++; if (fence_cnt_o !== 2'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", fence_cnt_o); end
    req_valid_i = 1'b0;
    rst_i = 1'b0;
    tick();
    exp_cnt = 2'd0;
  endtask

  // SFENCE with stores already drained: TLB pulse at cycle 2, ack at cycle 3, no D$ flush.
  task automatic test_sfence(input string tag);
    run_seq(2'd2, 6, '1, '0, '0, '0);
    exp_cnt = exp_cnt + 2'd1;
    total++; if (rec_busy   !== 64'hE) begin bad++; $display("FAIL %s_busy got=%h exp=%h", tag, rec_busy, 64'hE); end
    total++; if (rec_tlb    !== 64'h4) begin bad++; $display("FAIL %s_tlb got=%h exp=%h", tag, rec_tlb, 64'h4); end
    total++; if (rec_ack    !== 64'h8) begin bad++; $display("FAIL %s_ack got=%h exp=%h", tag, rec_ack, 64'h8); end
    total++; if (rec_dflush !== 64'h0) begin bad++; $display("FAIL %s_dflush got=%h exp=0", tag, rec_dflush); end
    total++; if (rec_iflush !== 64'h0) begin bad++; $display("FAIL %s_iflush got=%h exp=0", tag, rec_iflush); end
    total++; if (rec_tmo    !== 64'h0) begin bad++; $display("FAIL %s_tmo got=%h exp=0", tag, rec_tmo); end
    total++; if (fence_cnt_o !== exp_cnt) begin bad++; $display("FAIL %s_cnt got=%0d exp=%0d", tag, fence_cnt_o, exp_cnt); end
  endtask

  // FENCE_I: stores pending cycles 1-5, FLUSH_D cycles 7-10 with ack in cycle 10; stray ack in DRAIN ignored.
  task automatic test_fence_i();
    run_seq(2'd1, 14, 64'hFFFF_FFFF_FFFF_FFC0, 64'h408, '0, '0);
    exp_cnt = exp_cnt + 2'd1;
    total++; if (rec_dflush !== 64'h780)  begin bad++; $display("FAIL fencei_dflush got=%h exp=%h", rec_dflush, 64'h780); end
    total++; if (rec_iflush !== 64'h800)  begin bad++; $display("FAIL fencei_iflush got=%h exp=%h", rec_iflush, 64'h800); end
    total++; if (rec_ack    !== 64'h1000) begin bad++; $display("FAIL fencei_ack got=%h exp=%h", rec_ack, 64'h1000); end
    total++; if (rec_busy   !== 64'h1FFE) begin bad++; $display("FAIL fencei_busy got=%h exp=%h", rec_busy, 64'h1FFE); end
    total++; if (rec_tlb    !== 64'h0)    begin bad++; $display("FAIL fencei_tlb got=%h exp=0", rec_tlb); end
    total++; if (rec_tmo    !== 64'h60)   begin bad++; $display("FAIL fencei_tmo got=%h exp=%h", rec_tmo, 64'h60); end
    total++; if (fence_cnt_o !== exp_cnt) begin bad++; $display("FAIL fencei_cnt got=%0d exp=%0d", fence_cnt_o, exp_cnt); end
  endtask

  // FENCE with stores pending 10 cycles: timeout from 5th DRAIN cycle through the exit cycle 11.
  task automatic test_drain_timeout();
    run_seq(2'd0, 16, 64'hFFFF_FFFF_FFFF_F800, 64'h2000, '0, '0);
    exp_cnt = exp_cnt + 2'd1;
    total++; if (rec_tmo    !== 64'hFE0)  begin bad++; $display("FAIL timeout_tmo got=%h exp=%h", rec_tmo, 64'hFE0); end
    total++; if (rec_dflush !== 64'h3000) begin bad++; $display("FAIL timeout_dflush got=%h exp=%h", rec_dflush, 64'h3000); end
    total++; if (rec_ack    !== 64'h4000) begin bad++; $display("FAIL timeout_ack got=%h exp=%h", rec_ack, 64'h4000); end
    total++; if (rec_busy   !== 64'h7FFE) begin bad++; $display("FAIL timeout_busy got=%h exp=%h", rec_busy, 64'h7FFE); end
    total++; if (rec_iflush !== 64'h0)    begin bad++; $display("FAIL timeout_iflush got=%h exp=0", rec_iflush); end
    total++; if (rec_tlb    !== 64'h0)    begin bad++; $display("FAIL timeout_tlb got=%h exp=0", rec_tlb); end
    total++; if (fence_cnt_o !== exp_cnt) begin bad++; $display("FAIL timeout_cnt got=%0d exp=%0d", fence_cnt_o, exp_cnt); end
  endtask

  // Kill in DRAIN coinciding with drain completion in cycle 3: kill wins, back to IDLE.
  task automatic test_kill_drain();
    run_seq(2'd0, 8, 64'h8, '0, 64'h8, '0);
    total++; if (rec_busy   !== 64'hE) begin bad++; $display("FAIL kill_drain_busy got=%h exp=%h", rec_busy, 64'hE); end
    total++; if (rec_ack    !== 64'h0) begin bad++; $display("FAIL kill_drain_ack got=%h exp=0", rec_ack); end
    total++; if (rec_dflush !== 64'h0) begin bad++; $display("FAIL kill_drain_dflush got=%h exp=0", rec_dflush); end
    total++; if (rec_iflush !== 64'h0) begin bad++; $display("FAIL kill_drain_iflush got=%h exp=0", rec_iflush); end
    total++; if (rec_tlb    !== 64'h0) begin bad++; $display("FAIL kill_drain_tlb got=%h exp=0", rec_tlb); end
    total++; if (rec_tmo    !== 64'h0) begin bad++; $display("FAIL kill_drain_tmo got=%h exp=0", rec_tmo); end
    total++; if (fence_cnt_o !== exp_cnt) begin bad++; $display("FAIL kill_drain_cnt got=%0d exp=%0d", fence_cnt_o, exp_cnt); end
  endtask

  // DFLUSH with kill in FLUSH_D (cycles 2,3) and DONE (cycle 5): all ignored; counter wraps 3->0.
  task automatic test_kill_flush_d();
    run_seq(2'd3, 8, '1, 64'h10, 64'h2C, '0);
    exp_cnt = exp_cnt + 2'd1;
    total++; if (rec_dflush !== 64'h1C) begin bad++; $display("FAIL kill_fd_dflush got=%h exp=%h", rec_dflush, 64'h1C); end
    total++; if (rec_ack    !== 64'h20) begin bad++; $display("FAIL kill_fd_ack got=%h exp=%h", rec_ack, 64'h20); end
    total++; if (rec_busy   !== 64'h3E) begin bad++; $display("FAIL kill_fd_busy got=%h exp=%h", rec_busy, 64'h3E); end
    total++; if (rec_iflush !== 64'h0)  begin bad++; $display("FAIL kill_fd_iflush got=%h exp=0", rec_iflush); end
    total++; if (rec_tlb    !== 64'h0)  begin bad++; $display("FAIL kill_fd_tlb got=%h exp=0", rec_tlb); end
    total++; if (rec_tmo    !== 64'h0)  begin bad++; $display("FAIL kill_fd_tmo got=%h exp=0", rec_tmo); end
    total++; if (fence_cnt_o !== 2'd0)  begin bad++; $display("FAIL kill_fd_wrap got=%0d exp=0", fence_cnt_o); end
  endtask

  // Halt held cycles 0-2 blocks accept; accept at cycle 3; halt in cycles 5,6 has no effect.
  task automatic test_halt();
    run_seq(2'd0, 10, '1, 64'h40, '0, 64'h67);
    exp_cnt = exp_cnt + 2'd1;
    total++; if (rec_busy   !== 64'hF0) begin bad++; $display("FAIL halt_busy got=%h exp=%h", rec_busy, 64'hF0); end
    total++; if (rec_dflush !== 64'h60) begin bad++; $display("FAIL halt_dflush got=%h exp=%h", rec_dflush, 64'h60); end
    total++; if (rec_ack    !== 64'h80) begin bad++; $display("FAIL halt_ack got=%h exp=%h", rec_ack, 64'h80); end
    total++; if (rec_iflush !== 64'h0)  begin bad++; $display("FAIL halt_iflush got=%h exp=0", rec_iflush); end
    total++; if (rec_tlb    !== 64'h0)  begin bad++; $display("FAIL halt_tlb got=%h exp=0", rec_tlb); end
    total++; if (rec_tmo    !== 64'h0)  begin bad++; $display("FAIL halt_tmo got=%h exp=0", rec_tmo); end
    total++; if (fence_cnt_o !== exp_cnt) begin bad++; $display("FAIL halt_cnt got=%0d exp=%0d", fence_cnt_o, exp_cnt); end
  endtask

  // Request held through DONE: the second accept happens only from the IDLE cycle after DONE.
  task automatic test_back_to_back();
    logic [15:0] b_busy, b_ack, b_tlb;
    b_busy = '0; b_ack = '0; b_tlb = '0;
    req_valid_i = 1'b1; req_kind_i = 2'd2; no_st_pending_i = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      tick();
      b_busy[c] = busy_o; b_ack[c] = commit_ack_o; b_tlb[c] = tlb_flush_o;
      if (c == 7) req_valid_i = 1'b0;
    end
    idle_inputs();
    exp_cnt = exp_cnt + 2'd2;
    total++; if (b_busy !== 16'hEE) begin bad++; $display("FAIL b2b_busy got=%h exp=%h", b_busy, 16'hEE); end
    total++; if (b_ack  !== 16'h88) begin bad++; $display("FAIL b2b_ack got=%h exp=%h", b_ack, 16'h88); end
    total++; if (b_tlb  !== 16'h44) begin bad++; $display("FAIL b2b_tlb got=%h exp=%h", b_tlb, 16'h44); end
    total++; if (fence_cnt_o !== exp_cnt) begin bad++; $display("FAIL b2b_cnt got=%0d exp=%0d", fence_cnt_o, exp_cnt); end
  endtask

  // Reset while in FLUSH_D: everything returns to zero the next cycle, counter included.
  task automatic test_reset_mid();
    req_valid_i = 1'b1; req_kind_i = 2'd0; no_st_pending_i = 1'b1;
    tick();
    tick();
    total++; if (dcache_flush_o !== 1'b1) begin bad++; $display("FAIL rstmid_in_flush got=%b exp=1", dcache_flush_o); end
    req_valid_i = 1'b0;
    rst_i = 1'b1;
    tick();
    total++; if ({dcache_flush_o, icache_flush_o, tlb_flush_o, commit_ack_o, busy_o, drain_timeout_o} !== 6'b0) begin bad++; $display("FAIL rstmid_outputs got=%b exp=000000", {dcache_flush_o, icache_flush_o, tlb_flush_o, commit_ack_o, busy_o, drain_timeout_o}); end
    total++; if (fence_cnt_o !== 2'd0) begin bad++; $display("FAIL rstmid_cnt got=%0d exp=0", fence_cnt_o); end
    rst_i = 1'b0;
    exp_cnt = 2'd0;
    tick();
  endtask

  initial begin
    test_reset();
    test_sfence("sfence");
    test_fence_i();
    test_drain_timeout();
    test_kill_drain();
    test_kill_flush_d();
    test_halt();
    test_back_to_back();
    test_reset_mid();
    test_sfence("post_rst");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
